uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_param.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, parity modes, receiver states
// and the per-bit sample tick indices.
package uart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  localparam logic [3:0] TICK_SAMPLE_A = 4'd7;
  localparam logic [3:0] TICK_SAMPLE_B = 4'd8;
  localparam logic [3:0] TICK_SAMPLE_C = 4'd9;
  localparam logic [3:0] TICK_BIT_END  = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLKS_PER_TICK clocks,
// phase restarted by clear.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_TICK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clear || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 16x oversampling, 3-sample majority vote,
// optional parity, 1 or 2 stop bits, frame-error and break detection.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_TICK = 4,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_busy
);

  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS);
  localparam logic       HAS_PARITY = (PARITY != PARITY_NONE);
  localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);

  logic sync1, rx_s, rx_prev;

  rx_state_t state, state_n;
  logic       tick, tick_clear;
  logic [3:0] tick_idx, tick_idx_n, tick_nxt;
  logic [1:0] samp, samp_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic       stop_cnt, stop_cnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, data_n;
  logic par_bit, par_bit_n, ferr_acc, ferr_acc_n;
  logic done_n, perr_n, ferr_n, brk_n;
  logic start_edge, bit_val, decide, bit_end, exp_par, zero_frame;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_serial_in;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  uart_baud_tick #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign tick_nxt   = tick_idx + 4'd1;
  assign start_edge = rx_prev & ~rx_s;
  assign bit_val    = majority3(samp[0], samp[1], rx_s);
  assign decide     = tick && (tick_nxt == TICK_SAMPLE_C);
  assign bit_end    = tick && (tick_idx == TICK_BIT_END);
  assign exp_par    = (PARITY == PARITY_ODD) ? ~^shreg : ^shreg;
  assign zero_frame = (shreg == '0) && (!HAS_PARITY || !par_bit);
  assign rx_busy    = state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};

  always_comb begin
    state_n    = state;
    tick_clear = 1'b0;
    tick_idx_n = tick_idx;
    samp_n     = samp;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    ferr_acc_n = ferr_acc;
    done_n     = 1'b0;
    data_n     = rx_data_out;
    perr_n     = rx_parity_err;
    ferr_n     = rx_frame_err;
    brk_n      = rx_break;

    if (tick && rx_busy) begin
      tick_idx_n = tick_nxt;
      if (tick_nxt == TICK_SAMPLE_A) samp_n[0] = rx_s;
      if (tick_nxt == TICK_SAMPLE_B) samp_n[1] = rx_s;
    end

    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          state_n    = ST_START;
          tick_clear = 1'b1;
          tick_idx_n = '0;
          bit_cnt_n  = '0;
          stop_cnt_n = 1'b0;
          ferr_acc_n = 1'b0;
        end
      end
      ST_START: begin
        if (decide && bit_val)
          state_n = ST_IDLE;
        else if (bit_end)
          state_n = ST_DATA;
      end
      ST_DATA: begin
        if (decide) begin
          shreg_n   = {bit_val, shreg[DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + 4'd1;
        end
        if (bit_end && bit_cnt == LAST_DATA)
          state_n = HAS_PARITY ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        if (decide) par_bit_n = bit_val;
        if (bit_end) state_n = ST_STOP;
      end
      ST_STOP: begin
        // Frame completes at the tick-9 decision, not the bit end, so a
        // start bit immediately after the last stop bit is still caught.
        if (decide) begin
          if (!stop_cnt && !bit_val && zero_frame) begin
            done_n     = 1'b1;
            data_n     = shreg;
            perr_n     = HAS_PARITY && (par_bit != exp_par);
            ferr_n     = 1'b1;
            brk_n      = 1'b1;
            state_n    = ST_WAIT_IDLE;
            tick_clear = 1'b1;
          end else if (stop_cnt == LAST_STOP) begin
            done_n  = 1'b1;
            data_n  = shreg;
            perr_n  = HAS_PARITY && (par_bit != exp_par);
            ferr_n  = ferr_acc | ~bit_val;
            brk_n   = 1'b0;
            state_n = ST_IDLE;
          end else begin
            ferr_acc_n = ~bit_val;
            stop_cnt_n = 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // Holding the tick phase in clear while low means a tick only fires
        // after a full tick of uninterrupted high line.
        tick_clear = ~rx_s;
        if (tick && rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_WAIT_IDLE;
      tick_idx      <= '0;
      samp          <= '0;
      bit_cnt       <= '0;
      stop_cnt      <= 1'b0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      ferr_acc      <= 1'b0;
      rx_data_out   <= '0;
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      state         <= state_n;
      tick_idx      <= tick_idx_n;
      samp          <= samp_n;
      bit_cnt       <= bit_cnt_n;
      stop_cnt      <= stop_cnt_n;
      shreg         <= shreg_n;
      par_bit       <= par_bit_n;
      ferr_acc      <= ferr_acc_n;
      rx_data_out   <= data_n;
      rx_done       <= done_n;
      rx_parity_err <= perr_n;
      rx_frame_err  <= ferr_n;
      rx_break      <= brk_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receiver configurations (8N1, 7E1, 5O2)
// driven by a serial bit-level transmitter and checked against a frame model.
`timescale 1ns/100ps
module tb_uart_rx_param;

  localparam int      CPT   = 4;
  localparam realtime BIT_T = 1280.0;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] ser;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [4:0] d2;
  logic [2:0] done, perr, ferr, brk, busy;

  always #10 clk = ~clk;

  uart_rx_param #(.CLKS_PER_TICK(CPT)) dut0 (
    .clk(clk), .rst(rst), .rx_serial_in(ser[0]), .rx_data_out(d0), .rx_done(done[0]),
    .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]), .rx_break(brk[0]), .rx_busy(busy[0]));

  uart_rx_param #(.CLKS_PER_TICK(CPT), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .rx_serial_in(ser[1]), .rx_data_out(d1), .rx_done(done[1]),
    .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]), .rx_break(brk[1]), .rx_busy(busy[1]));

  uart_rx_param #(.CLKS_PER_TICK(CPT), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .rx_serial_in(ser[2]), .rx_data_out(d2), .rx_done(done[2]),
    .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]), .rx_break(brk[2]), .rx_busy(busy[2]));

  typedef struct {
    int         ch;
    logic [8:0] data;
    logic       perr, ferr, brk;
    realtime    t;
    logic       lat;
  } rec_t;

  rec_t got_q[$];
  rec_t exp_q[$];
  int unsigned passed = 0, fails = 0, total = 0;

  function automatic int nbits_of(input int ch);
    case (ch) 0: return 8; 1: return 7; default: return 5; endcase
  endfunction
  function automatic int pmode_of(input int ch);
    case (ch) 0: return 0; 1: return 2; default: return 1; endcase
  endfunction
  function automatic int nstop_of(input int ch);
    return (ch == 2) ? 2 : 1;
  endfunction

  function automatic rec_t mk_rec(input int ch, input logic [8:0] d, input logic p,
                                  input logic f, input logic b);
    rec_t r;
    r.ch = ch; r.data = d; r.perr = p; r.ferr = f; r.brk = b;
    r.t = $realtime; r.lat = 1'b0;
    return r;
  endfunction

  // Parity bit a transmitter would send: odd mode makes the total count of
  // ones odd, even mode makes it even.
  function automatic logic good_parity(input int ch, input logic [8:0] d);
    int ones;
    ones = $countones(d);
    if (pmode_of(ch) == 1) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  function automatic rec_t model(input int ch, input logic [8:0] d, input logic pbit,
                                 input logic [1:0] st);
    rec_t r;
    int   pm;
    pm = pmode_of(ch);
    r = mk_rec(ch, d, 1'b0, 1'b0, 1'b0);
    r.perr = (pm != 0) && (pbit != good_parity(ch, d));
    r.brk  = (d == 9'd0) && (pm == 0 || !pbit) && !st[0];
    r.ferr = r.brk || !st[0] || (nstop_of(ch) == 2 && !st[1]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (done[0]) got_q.push_back(mk_rec(0, {1'b0, d0}, perr[0], ferr[0], brk[0]));
    if (done[1]) got_q.push_back(mk_rec(1, {2'b0, d1}, perr[1], ferr[1], brk[1]));
    if (done[2]) got_q.push_back(mk_rec(2, {4'b0, d2}, perr[2], ferr[2], brk[2]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input int ch, input logic [8:0] d, input logic flip,
                            input logic [1:0] st, input realtime bt, input logic lat);
    logic [15:0] bits;
    logic [8:0]  dm;
    logic        pbit;
    int          n, nb;
    rec_t        e;
    nb   = nbits_of(ch);
    dm   = d & 9'((1 << nb) - 1);
    pbit = good_parity(ch, dm) ^ flip;
    bits = '0;
    n    = 1;
    for (int i = 0; i < nb; i++) begin bits[n] = dm[i]; n++; end
    if (pmode_of(ch) != 0) begin bits[n] = pbit; n++; end
    for (int s = 0; s < nstop_of(ch); s++) begin bits[n] = st[s]; n++; end
    e = model(ch, dm, pbit, st);
    e.lat = lat;
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      ser[ch] = bits[i];
      #(bt);
    end
    ser[ch] = 1'b1;
  endtask

  task automatic check_next(input string tag);
    int   n, cyc, lo, hi, nfr;
    rec_t g, e;
    n = 0;
    while (got_q.size() == 0 && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_arrived"}, 32'(got_q.size() != 0), 32'd1);
    if (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_ch"},   32'(g.ch),   32'(e.ch));
      chk({tag, "_data"}, 32'(g.data), 32'(e.data));
      chk({tag, "_perr"}, 32'(g.perr), 32'(e.perr));
      chk({tag, "_ferr"}, 32'(g.ferr), 32'(e.ferr));
      chk({tag, "_brk"},  32'(g.brk),  32'(e.brk));
      if (e.lat && !e.brk) begin
        nfr = 1 + nbits_of(e.ch) + ((pmode_of(e.ch) != 0) ? 1 : 0) + nstop_of(e.ch);
        lo  = ((nfr - 1) * 16 + 10) * CPT - CPT;
        hi  = ((nfr - 1) * 16 + 10) * CPT + CPT + 3;  // line fall -> synchronized edge
        cyc = int'((g.t - e.t) / 20.0);
        chk($sformatf("%s_latency_%0dclk", tag, cyc), 32'(cyc >= lo && cyc <= hi), 32'd1);
      end
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_quiet(input string tag);
    chk(tag, 32'(got_q.size()), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t       e;
    logic [1:0] st;
    ser = '1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data0", 32'(d0), 32'd0);
    chk("reset_status", 32'({done, perr, ferr, brk, busy}), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    send_frame(0, 9'h41, 1'b0, 2'b11, BIT_T, 1'b1);
    send_frame(0, 9'h42, 1'b0, 2'b11, BIT_T, 1'b1);
    check_next("b2b_41");
    check_next("b2b_42");
    #(BIT_T);

    send_frame(1, 9'h55, 1'b1, 2'b11, BIT_T, 1'b1);
    check_next("par_bad");
    send_frame(1, 9'h55, 1'b0, 2'b11, BIT_T, 1'b1);
    check_next("par_ok");

    send_frame(0, 9'hA5, 1'b0, 2'b00, BIT_T, 1'b1);
    check_next("stop_low");
    #(BIT_T);

    ser[0] = 1'b0;
    repeat (12) @(negedge clk);
    ser[0] = 1'b1;
    repeat (3 * 64) @(negedge clk);
    check_quiet("glitch_no_done");
    chk("glitch_not_busy", 32'(busy[0]), 32'd0);
    send_frame(0, 9'h3C, 1'b0, 2'b11, BIT_T, 1'b1);
    check_next("after_glitch");
    check_quiet("after_glitch_single");

    e = model(0, 9'h000, 1'b0, 2'b00);
    exp_q.push_back(e);
    ser[0] = 1'b0;
    #(12 * BIT_T);
    check_next("break");
    check_quiet("break_single");
    ser[0] = 1'b1;
    #(2 * BIT_T);
    send_frame(0, 9'h7E, 1'b0, 2'b11, BIT_T, 1'b1);
    check_next("after_break");

    send_frame(0, 9'h5A, 1'b0, 2'b11, BIT_T * 1.03, 1'b0);
    check_next("baud_slow");
    #(BIT_T);
    send_frame(0, 9'h96, 1'b0, 2'b11, BIT_T * 0.97, 1'b0);
    check_next("baud_fast");
    #(BIT_T);

    // 0xF0 LSB first: start, four 0s, then four 1s; reset lands after bit 3
    ser[0] = 1'b0;
    #(5 * BIT_T);
    chk("busy_mid_frame", 32'(busy[0]), 32'd1);
    ser[0] = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_async_data0", 32'(d0), 32'd0);
    chk("rst_async_data1", 32'(d1), 32'd0);
    chk("rst_async_status", 32'({done, perr, ferr, brk, busy}), 32'd0);
    #199;
    rst = 1'b0;
    #(4 * BIT_T - 200.0);
    #(3 * BIT_T);
    check_quiet("rst_discard");

    ser[0] = 1'b0;
    #(2 * BIT_T);
    rst = 1'b1;
    #200;
    rst = 1'b0;
    #(3 * BIT_T);
    ser[0] = 1'b1;
    #(3 * BIT_T);
    check_quiet("rst_line_low");
    send_frame(0, 9'h81, 1'b0, 2'b11, BIT_T, 1'b1);
    check_next("after_rst");

    send_frame(2, 9'h13, 1'b0, 2'b11, BIT_T, 1'b1);
    check_next("p2_ok");
    send_frame(2, 9'h0A, 1'b1, 2'b01, BIT_T, 1'b1);
    check_next("p2_bad_stop2");

    for (int ch = 0; ch < 3; ch++) begin
      for (int k = 0; k < 12; k++) begin
        st[0] = ($urandom_range(0, 7) != 0);
        st[1] = ($urandom_range(0, 7) != 0);
        send_frame(ch, 9'($urandom), ($urandom_range(0, 3) == 0), st, BIT_T, 1'b1);
        check_next($sformatf("rand_ch%0d_%0d", ch, k));
        #(BIT_T * $urandom_range(1, 2));
      end
    end
    check_quiet("final_no_extra");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
